jhash_arb: RTL and testbench

Scheduler and arbiter that shares one `jhash_core` between two requesters. It grants the core to one requester at a time and packs that requester's 32-bit words into triples. Each triple goes to the core over the `stream_valid`/`stream_ack` handshake, and the last 0–3 words go with `stream_done`/`stream_left`. The block captures the hash, returns it to the owner, and resets the core so it is ready for the next job.

---
 rtl/jhash_arb.sv | 206 ++++++++++++++++++++
 tb/tb_jhash_arb.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jhash_arb.sv
// jhash_arb: shares one jhash_core between two requesters.
// Grants the core to one requester at a time, packs its 32-bit words into
// triples for the core, sends the last 0..3 words with stream_done, captures
// the hash for the owner and then resets the core for the next job.
// Optional build macro JHASH_ARB_FIXED_PRIO_EN selects fixed priority
// (requester 0 always wins); when undefined, ties are resolved round-robin.

module jhash_arb #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [31:0]      wdata0,
    input  logic [31:0]      wdata1,
    input  logic [1:0]       wvalid,
    output logic [1:0]       wack,
    output logic [31:0]      res_hash,
    output logic [1:0]       res_valid,
    output logic             busy,
    output logic             core_rst,
    output logic [31:0]      stream_data0,
    output logic [31:0]      stream_data1,
    output logic [31:0]      stream_data2,
    output logic             stream_valid,
    output logic             stream_done,
    output logic [1:0]       stream_left,
    input  logic             stream_ack,
    input  logic             hash_done,
    input  logic [31:0]      hash_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FILL,
        S_SEND,
        S_LAST,
        S_CLR
    } state_t;

    state_t           state;
    logic             grant;
    logic [LEN_W-1:0] rem;
    logic [1:0]       fill;
    logic [2:0]       hold;
    logic [31:0]      slot0;
    logic [31:0]      slot1;
    logic [31:0]      slot2;

    logic             winner;
    logic [LEN_W-1:0] win_len;
    logic             own_wvalid;
    logic [31:0]      own_wdata;
    logic             accept;
    logic [1:0]       fill_nxt;
    logic [LEN_W-1:0] rem_nxt;

`ifdef JHASH_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        winner = ~req[0];
    end
`else
    logic last_grant;

    // Round-robin: on a tie the requester that was not granted last wins.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_grant;
        end
    end
`endif

    assign win_len    = winner ? len1 : len0;
    assign own_wvalid = grant ? wvalid[1] : wvalid[0];
    assign own_wdata  = grant ? wdata1 : wdata0;

    // A word is taken only while a slot is free and the job still owes words.
    assign accept   = (state == S_FILL) && own_wvalid && (fill != 2'd3) && (rem != '0);
    assign fill_nxt = accept ? fill + 2'd1 : fill;
    assign rem_nxt  = accept ? rem - LEN_W'(1) : rem;

    assign wack = {accept & grant, accept & ~grant};
    assign busy = (state != S_IDLE);

    // Decode the core-side stream signals from the current state and slots.
    always_comb begin
        stream_valid = 1'b0;
        stream_done  = 1'b0;
        stream_left  = 2'd0;
        stream_data0 = '0;
        stream_data1 = '0;
        stream_data2 = '0;
        case (state)
            S_PRIME: begin
                stream_valid = 1'b1;
            end
            S_SEND: begin
                stream_valid = 1'b1;
                stream_data0 = slot0;
                stream_data1 = slot1;
                stream_data2 = slot2;
            end
            S_LAST: begin
                if (hold == 3'd0) begin
                    stream_done = 1'b1;
                    stream_left = fill;
                    if (fill >= 2'd1) stream_data0 = slot0;
                    if (fill >= 2'd2) stream_data1 = slot1;
                    if (fill == 2'd3) stream_data2 = slot2;
                end
            end
            default: begin
            end
        endcase
    end

    // Job sequencing: grant, prime the core, pack triples, finish, reset core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            grant     <= 1'b0;
            rem       <= '0;
            fill      <= 2'd0;
            hold      <= 3'd0;
            slot0     <= '0;
            slot1     <= '0;
            slot2     <= '0;
            res_hash  <= '0;
            res_valid <= 2'b00;
            core_rst  <= 1'b1;
`ifdef JHASH_ARB_FIXED_PRIO_EN
`else
            last_grant <= 1'b1;
`endif
        end else begin
            res_valid <= 2'b00;
            core_rst  <= 1'b0;
            if (hold != 3'd0) begin
                hold <= hold - 3'd1;
            end
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        grant <= winner;
                        rem   <= win_len;
                        fill  <= 2'd0;
                        state <= S_PRIME;
`ifdef JHASH_ARB_FIXED_PRIO_EN
`else
                        last_grant <= winner;
`endif
                    end
                end
                S_PRIME: begin
                    state <= S_FILL;
                end
                S_FILL: begin
                    if (accept) begin
                        case (fill)
                            2'd0:    slot0 <= own_wdata;
                            2'd1:    slot1 <= own_wdata;
                            2'd2:    slot2 <= own_wdata;
                            default: begin
                            end
                        endcase
                    end
                    fill <= fill_nxt;
                    rem  <= rem_nxt;
                    if (rem_nxt == '0) begin
                        state <= S_LAST;
                    end else if (fill_nxt == 2'd3) begin
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (stream_ack) begin
                        fill  <= 2'd0;
                        hold  <= 3'd6;
                        state <= S_FILL;
                    end
                end
                S_LAST: begin
                    if (hash_done) begin
                        res_hash  <= hash_out;
                        res_valid <= grant ? 2'b10 : 2'b01;
                        core_rst  <= 1'b1;
                        state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    grant <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jhash_arb.sv
// tb_jhash_arb: randomized self-checking bench for jhash_arb.
// Contains a stub core that mixes the streamed triples into a hash and a
// reference model that derives the expected hash, packing, arbitration
// order and timing of every job straight from the word lists.

module tb_jhash_arb;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [31:0]      wdata0;
    logic [31:0]      wdata1;
    logic [1:0]       wvalid;
    logic [1:0]       wack;
    logic [31:0]      res_hash;
    logic [1:0]       res_valid;
    logic             busy;
    logic             core_rst;
    logic [31:0]      sd0;
    logic [31:0]      sd1;
    logic [31:0]      sd2;
    logic             stream_valid;
    logic             stream_done;
    logic [1:0]       stream_left;
    logic             stream_ack;
    logic             hash_done;
    logic [31:0]      hash_out;

    jhash_arb #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1), .wvalid(wvalid), .wack(wack),
        .res_hash(res_hash), .res_valid(res_valid), .busy(busy), .core_rst(core_rst),
        .stream_data0(sd0), .stream_data1(sd1), .stream_data2(sd2),
        .stream_valid(stream_valid), .stream_done(stream_done), .stream_left(stream_left),
        .stream_ack(stream_ack), .hash_done(hash_done), .hash_out(hash_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int base;
        int vmode;
    } job_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    job_t        jobs0[$];
    job_t        jobs1[$];
    int          order_q[$];
    bit          pend[2];
    bit          tog[2];
    int          cur_len[2];
    int          cur_vmode[2];
    int          wptr[2];
    logic [31:0] wmem[2][256];
    logic [31:0] exp_hash[2];
    int          exp_left[2];
    int          exp_acks[2];

    logic [1:0]  prev_req;
    bit          prev_busy;
    int          exp_owner = -1;
    int          last_owner = 1;
    int          rise_cyc;
    int          done_cyc;
    bit          done_valid;

    int          cst;
    int          mix;
    int          hcnt;
    logic [31:0] hacc;
    bit          done_seen;
    bit          sv_seen;
    logic [31:0] sv_d0;
    logic [31:0] sv_d1;
    logic [31:0] sv_d2;
    int          sv_wait;
    int          job_acks;
    int          last_ack;
    int          prime_cyc;
    bit          hold_ack;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] mix_fn(input logic [31:0] h, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c, input int k);
        return ({h[26:0], h[31:27]} ^ a) + (b * 32'd3) + (c ^ (32'h5bd1e995 + 32'(k)));
    endfunction

    function automatic int arbitrate(input logic [1:0] rq);
        if (rq == 2'b11) begin
`ifdef JHASH_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last_owner;
`endif
        end
        return rq[1] ? 1 : 0;
    endfunction

    task automatic pushJob(input int r, input int len, input int base, input int vmode);
        job_t j;
        j.len = len;
        j.base = base;
        j.vmode = vmode;
        if (r == 0) jobs0.push_back(j);
        else jobs1.push_back(j);
    endtask

    task automatic startJob(input int r);
        job_t        j;
        int          nf;
        int          lf;
        logic [31:0] h;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        if (r == 0) j = jobs0.pop_front();
        else j = jobs1.pop_front();
        cur_len[r] = j.len;
        cur_vmode[r] = j.vmode;
        wptr[r] = 0;
        pend[r] = 1'b1;
        for (int i = 0; i < j.len; i++) begin
            wmem[r][i] = (j.base != 0) ? 32'(j.base + i) : $urandom;
        end
        nf = (j.len == 0) ? 0 : (j.len - 1) / 3;
        lf = j.len - 3 * nf;
        h = '0;
        for (int t = 0; t < nf; t++) begin
            h = mix_fn(h, wmem[r][3*t], wmem[r][3*t+1], wmem[r][3*t+2], 0);
        end
        a = (lf > 0) ? wmem[r][3*nf] : 32'd0;
        b = (lf > 1) ? wmem[r][3*nf+1] : 32'd0;
        c = (lf > 2) ? wmem[r][3*nf+2] : 32'd0;
        exp_hash[r] = mix_fn(h, a, b, c, 16 + lf);
        exp_left[r] = lf;
        exp_acks[r] = nf;
        if (r == 0) len0 = LEN_W'(j.len);
        else len1 = LEN_W'(j.len);
    endtask

    task automatic stubReset();
        cst = 0;
        mix = 0;
        hcnt = 0;
        hacc = '0;
        done_seen = 1'b0;
        sv_seen = 1'b0;
        stream_ack = 1'b0;
        hash_done = 1'b0;
        hash_out = '0;
    endtask

    // Stub core: prime on first valid, ack triples after its mix rounds,
    // and raise hash_done eight cycles after the first stream_done.
    task automatic coreStub();
        int o;
        stream_ack = 1'b0;
        o = (exp_owner < 0) ? 0 : exp_owner;
        if (core_rst) begin
            stubReset();
        end else if (cst == 0) begin
            if (stream_valid) begin
                cst = 1;
                prime_cyc = cyc;
                job_acks = 0;
                last_ack = -100;
                sv_seen = 1'b0;
                checkOutput("prime_data", sd0 | sd1 | sd2, 32'd0);
                checkOutput("prime_at_grant", 32'(cyc), 32'(rise_cyc));
            end
        end else begin
            if (mix > 0) mix--;
            if (stream_valid) begin
                if (!sv_seen) begin
                    sv_seen = 1'b1;
                    sv_d0 = sd0;
                    sv_d1 = sd1;
                    sv_d2 = sd2;
                    sv_wait = $urandom_range(0, 2);
                end else begin
                    checkOutput("send_stable", (sd0 ^ sv_d0) | (sd1 ^ sv_d1) | (sd2 ^ sv_d2), 32'd0);
                end
                if (!hold_ack && mix == 0 && sv_wait == 0) begin
                    stream_ack = 1'b1;
                    hacc = mix_fn(hacc, sd0, sd1, sd2, 0);
                    mix = 6;
                    last_ack = cyc;
                    job_acks++;
                    sv_seen = 1'b0;
                end else if (sv_wait > 0) begin
                    sv_wait--;
                end
            end
            if (done_seen) begin
                if (!hash_done) begin
                    hcnt--;
                    if (hcnt == 0) begin
                        hash_done = 1'b1;
                        hash_out = hacc;
                    end
                end
            end else if (stream_done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                done_valid = 1'b1;
                hcnt = 8;
                checkOutput("stream_left", 32'(stream_left), 32'(exp_left[o]));
                checkOutput("unused_zero", ((stream_left < 2'd1) ? sd0 : 32'd0) |
                            ((stream_left < 2'd2) ? sd1 : 32'd0) |
                            ((stream_left < 2'd3) ? sd2 : 32'd0), 32'd0);
                if (job_acks > 0) begin
                    if (cur_vmode[o] == 0) checkOutput("done_after_ack", 32'(cyc - last_ack), 32'd7);
                    else checkOutput("done_hold", 32'(cyc - last_ack >= 7), 32'd1);
                end else if (cur_vmode[o] == 0) begin
                    checkOutput("done_latency", 32'(cyc - prime_cyc),
                                32'((cur_len[o] == 0) ? 2 : cur_len[o] + 1));
                end
                hacc = mix_fn(hacc, sd0, sd1, sd2, 16 + int'(stream_left));
            end
        end
    endtask

    // One clock of stimulus: drive requesters at negedge, then sample and check.
    task automatic applyStimulus();
        logic [1:0] wv;
        bit         v;
        @(negedge clk);
        cyc++;
        prev_req = req;
        if (!pend[0] && jobs0.size() > 0) startJob(0);
        if (!pend[1] && jobs1.size() > 0) startJob(1);
        req = {pend[1], pend[0]};
        wv = 2'b00;
        for (int r = 0; r < 2; r++) begin
            if (pend[r] && wptr[r] < cur_len[r]) begin
                case (cur_vmode[r])
                    0:       v = 1'b1;
                    1:       v = tog[r];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                tog[r] = ~tog[r];
                wv[r] = v;
                if (r == 0) wdata0 = wmem[0][wptr[0]];
                else wdata1 = wmem[1][wptr[1]];
            end
        end
        wvalid = wv;
        #1;
        if (busy && !prev_busy) begin
            exp_owner = arbitrate(prev_req);
            last_owner = exp_owner;
            rise_cyc = cyc;
        end
        prev_busy = busy;
        for (int r = 0; r < 2; r++) begin
            if (wack[r]) begin
                checkOutput("wack_owner", 32'(r), 32'(exp_owner));
                checkOutput("wack_needs_wvalid", 32'(wvalid[r]), 32'd1);
                checkOutput("wack_has_word", 32'(wptr[r] < cur_len[r]), 32'd1);
                if (wptr[r] < 255) wptr[r]++;
            end
        end
        checkOutput("core_rst", 32'(core_rst), 32'(done_valid && cyc == done_cyc + 9));
        if (res_valid != 2'b00) begin
            if (exp_owner < 0 || !pend[exp_owner]) begin
                checkOutput("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                checkOutput("res_owner", 32'(res_valid), 32'(1 << exp_owner));
                checkOutput("res_hash", res_hash, exp_hash[exp_owner]);
                checkOutput("res_latency", 32'(cyc - done_cyc), 32'd9);
                checkOutput("wack_count", 32'(wptr[exp_owner]), 32'(cur_len[exp_owner]));
                checkOutput("ack_count", 32'(job_acks), 32'(exp_acks[exp_owner]));
                order_q.push_back(exp_owner);
                pend[exp_owner] = 1'b0;
            end
        end else if (done_valid && cyc == done_cyc + 9) begin
            checkOutput("res_missing", 32'(res_valid), 32'd1);
        end
        if (done_valid && cyc == done_cyc + 10) begin
            checkOutput("busy_drop", 32'(busy), 32'd0);
            done_valid = 1'b0;
        end
        coreStub();
    endtask

    task automatic runJobs(input int budget);
        int n;
        n = 0;
        while ((jobs0.size() > 0 || jobs1.size() > 0 || pend[0] || pend[1]) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("jobs_drained", 32'(jobs0.size() + jobs1.size() + int'(pend[0]) + int'(pend[1])), 32'd0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_wack"}, 32'(wack), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_res_hash"}, res_hash, 32'd0);
        checkOutput({tag, "_stream_ctl"}, 32'({stream_valid, stream_done, stream_left}), 32'd0);
        checkOutput({tag, "_stream_data"}, sd0 | sd1 | sd2, 32'd0);
        checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    endtask

    task automatic clearModel();
        jobs0.delete();
        jobs1.delete();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        tog[0] = 1'b1;
        tog[1] = 1'b1;
        req = 2'b00;
        wvalid = 2'b00;
        exp_owner = -1;
        last_owner = 1;
        prev_busy = 1'b0;
        done_valid = 1'b0;
        hold_ack = 1'b0;
        stubReset();
    endtask

    int exp_order[3];
    int n;

    initial begin
        rst_n = 1'b1;
        len0 = '0;
        len1 = '0;
        wdata0 = '0;
        wdata1 = '0;
        clearModel();
        #2 rst_n = 1'b0;
        #1 checkReset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("core_rst_release", 32'(core_rst), 32'd0);

        $display("[TB] directed: len 3, len 0, len 7");
        pushJob(0, 3, 1, 0);
        runJobs(200);
        pushJob(0, 0, 0, 0);
        runJobs(200);
        pushJob(1, 7, 100, 0);
        runJobs(300);

        $display("[TB] arbitration order");
        order_q.delete();
`ifdef JHASH_ARB_FIXED_PRIO_EN
        pushJob(0, 1, 10, 0);
        pushJob(0, 1, 20, 0);
        pushJob(0, 1, 30, 0);
        pushJob(1, 1, 40, 0);
        exp_order = '{0, 0, 0};
`else
        pushJob(0, 1, 10, 0);
        pushJob(0, 1, 20, 0);
        pushJob(1, 1, 40, 0);
        exp_order = '{0, 1, 0};
`endif
        runJobs(400);
        checkOutput("order_len", 32'(order_q.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < order_q.size()) checkOutput("grant_order", 32'(order_q[i]), 32'(exp_order[i]));
        end

        $display("[TB] toggling wvalid, len 6");
        pushJob(0, 6, 500, 1);
        runJobs(300);

        $display("[TB] random jobs");
        for (int i = 0; i < 24; i++) begin
            pushJob($urandom_range(0, 1), $urandom_range(0, 12), 0, 2);
        end
        runJobs(6000);

        $display("[TB] reset during send");
        hold_ack = 1'b1;
        pushJob(0, 9, 200, 0);
        n = 0;
        while (!sv_seen && n < 200) begin
            applyStimulus();
            n++;
        end
        checkOutput("reached_send", 32'(stream_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 checkReset("mid_reset");
        clearModel();
        repeat (3) @(posedge clk);
        #1 checkOutput("core_rst_held", 32'(core_rst), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("core_rst_release2", 32'(core_rst), 32'd0);
        pushJob(0, 5, 0, 2);
        pushJob(1, 4, 0, 0);
        runJobs(600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
